// File: rtl/d5m_stream_pkg.sv
// Shared types and constants for the synthetic D5M pixel source.
package d5m_stream_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    VBLANK,
    SETUP,
    ACTIVE,
    HBLANK,
    HOLD
  } state_e;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BAYER = 2'd3;

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/d5m_stream_gen_if.sv
// Parallel camera-style video bus: frame valid, line valid and raw pixel.
interface d5m_stream_gen_if;
  logic [d5m_stream_pkg::DATA_W-1:0] oDATA;
  logic                              oFVAL;
  logic                              oLVAL;

  modport master (output oDATA, output oFVAL, output oLVAL);
  modport slave  (input  oDATA, input  oFVAL, input  oLVAL);
endinterface

// File: rtl/d5m_pattern_lut.sv
// Combinational test-pattern generator: pixel coordinates and pattern code to raw Bayer value.
module d5m_pattern_lut
  import d5m_stream_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [1:0]        pat_i,
  output logic [DATA_W-1:0] pix_o
);

  always_comb begin
    pix_o = '0;
    case (pat_i)
      PAT_HRAMP: pix_o = x_i;
      PAT_VRAMP: pix_o = y_i;
      PAT_CHECK: pix_o = (x_i[4] ^ y_i[4]) ? 12'hFFF : 12'h000;
      default: begin
        // Bayer sites on {row parity, column parity}: G R / B G
        case ({y_i[0], x_i[0]})
          2'b01:   pix_o = 12'hFFF;
          2'b10:   pix_o = 12'h000;
          default: pix_o = 12'h800;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/d5m_stream_gen.sv
// Synthetic D5M transmitter: FVAL/LVAL/12-bit data with programmable geometry and frame counting.
module d5m_stream_gen
  import d5m_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 1000,
  parameter int FV_SETUP = 8,
  parameter int FV_HOLD  = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic                 iEND,
  input  logic [1:0]           iPATTERN,
  d5m_stream_gen_if.master     vid,
  output logic [31:0]          oFrame_Cont
);

  localparam int PH_MAX = max2(max2(max2(H_ACTIVE, H_BLANK), max2(V_BLANK, FV_SETUP)), FV_HOLD);
  localparam int CNT_W  = cnt_w(PH_MAX);
  localparam int X_W    = cnt_w(H_ACTIVE);
  localparam int Y_W    = cnt_w(V_ACTIVE);

  localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(FV_SETUP - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(FV_HOLD - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              run_q, run_d;
  logic [1:0]        pat_q, pat_d;
  logic              inc_q, inc_d;
  logic [31:0]       frame_q;
  logic              fval_q, lval_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] pix;

  d5m_pattern_lut u_lut (
    .x_i   (DATA_W'(x_q)),
    .y_i   (DATA_W'(y_q)),
    .pat_i (pat_q),
    .pix_o (pix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    pat_d   = pat_q;
    inc_d   = 1'b0;

    if (iEND)                          run_d = 1'b0;
    else if (state_q == IDLE && iSTART) run_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iSTART && !iEND) state_d = VBLANK;
      end
      VBLANK: begin
        if (cnt_q == VB_LAST) begin
          cnt_d = '0;
          if (run_d) begin
            state_d = SETUP;
            pat_d   = iPATTERN;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SU_LAST) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        x_d = x_q + X_W'(1);
        if (cnt_q == HA_LAST) begin
          cnt_d = '0;
          x_d   = '0;
          if (y_q == Y_LAST) begin
            state_d = HOLD;
          end else begin
            y_d     = y_q + Y_W'(1);
            state_d = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end
      end
      HOLD: begin
        if (cnt_q == HO_LAST) begin
          cnt_d   = '0;
          inc_d   = 1'b1;
          state_d = run_d ? VBLANK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the current state, so they trail the FSM by one edge;
  // the frame-count bump is delayed to land on the edge where FVAL falls.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= 1'b0;
      pat_q   <= PAT_HRAMP;
      inc_q   <= 1'b0;
      frame_q <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      pat_q   <= pat_d;
      inc_q   <= inc_d;
      frame_q <= frame_q + 32'(inc_q);
      fval_q  <= (state_q != IDLE) && (state_q != VBLANK);
      lval_q  <= (state_q == ACTIVE);
      data_q  <= (state_q == ACTIVE) ? pix : '0;
    end
  end

  assign vid.oDATA   = data_q;
  assign vid.oFVAL   = fval_q;
  assign vid.oLVAL   = lval_q;
  assign oFrame_Cont = frame_q;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Directed bench for d5m_stream_gen with a small 8x4 geometry (45-cycle frame period).
module tb_d5m_stream_gen;
  import d5m_stream_pkg::*;

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic        iEND = 1'b0;
  logic [1:0]  iPATTERN = 2'd0;
  logic [31:0] oFrame_Cont;

  int checks = 0;
  int errors = 0;

  d5m_stream_gen_if vid ();

  d5m_stream_gen #(
    .H_ACTIVE (8),
    .H_BLANK  (2),
    .V_ACTIVE (4),
    .V_BLANK  (3),
    .FV_SETUP (2),
    .FV_HOLD  (2)
  ) dut (
    .iCLK        (clk),
    .iRST        (iRST),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .iPATTERN    (iPATTERN),
    .vid         (vid),
    .oFrame_Cont (oFrame_Cont)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_pix(input int pat, input int x, input int y);
    case (pat)
      0: return 12'(x);
      1: return 12'(y);
      2: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: begin
        if ((y % 2) == 0) return ((x % 2) != 0) ? 12'hFFF : 12'h800;
        else              return ((x % 2) != 0) ? 12'h800 : 12'h000;
      end
    endcase
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (vid.oFVAL !== 1'b0) begin errors++; $display("FAIL reset_fval got %b want 0", vid.oFVAL); end
    checks++; if (vid.oLVAL !== 1'b0) begin errors++; $display("FAIL reset_lval got %b want 0", vid.oLVAL); end
    checks++; if (vid.oDATA !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", vid.oDATA); end
    checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", oFrame_Cont); end
  endtask

  // Called just after a negedge; leaves the bench at the first oFVAL-high sample.
  task automatic test_start_timing();
    iRST   = 1'b0;
    iSTART = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if (vid.oFVAL !== 1'b0) begin errors++; $display("FAIL start_fval_early n=%0d got %b want 0", n, vid.oFVAL); end
    end
    @(negedge clk);
    checks++; if (vid.oFVAL !== 1'b1) begin errors++; $display("FAIL start_fval_rise got %b want 1", vid.oFVAL); end
    checks++; if (vid.oLVAL !== 1'b0) begin errors++; $display("FAIL start_lval_setup got %b want 0", vid.oLVAL); end
  endtask

  // Walks one 45-cycle period from the first oFVAL-high sample (k=0).
  task automatic check_frame(input int pat, input int cnt_after, input int new_pat, input bit do_end);
    logic        e_fval, e_lval;
    logic [11:0] e_data;
    int          j, line, pos, e_cnt;
    for (int k = 0; k < 45; k++) begin
      e_fval = (k < 42);
      e_lval = 1'b0;
      e_data = 12'h000;
      if (k >= 2 && k < 40) begin
        j    = k - 2;
        line = j / 10;
        pos  = j % 10;
        if (pos < 8) begin
          e_lval = 1'b1;
          e_data = exp_pix(pat, pos, line);
        end
      end
      e_cnt = (k < 42) ? cnt_after - 1 : cnt_after;
      checks++;
      if (vid.oFVAL !== e_fval) begin errors++; $display("FAIL frame_fval pat=%0d k=%0d got %b want %b", pat, k, vid.oFVAL, e_fval); end
      checks++;
      if (vid.oLVAL !== e_lval) begin errors++; $display("FAIL frame_lval pat=%0d k=%0d got %b want %b", pat, k, vid.oLVAL, e_lval); end
      checks++;
      if (vid.oDATA !== e_data) begin errors++; $display("FAIL frame_data pat=%0d k=%0d got %h want %h", pat, k, vid.oDATA, e_data); end
      checks++;
      if (oFrame_Cont !== 32'(e_cnt)) begin errors++; $display("FAIL frame_cnt pat=%0d k=%0d got %0d want %0d", pat, k, oFrame_Cont, e_cnt); end
      if (k == 20) iPATTERN = 2'(new_pat);
      if (do_end && k == 25) begin iEND = 1'b1; iSTART = 1'b0; end
      if (do_end && k == 26) iEND = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_idle_after_end();
    for (int n = 0; n < 60; n++) begin
      checks++;
      if (vid.oFVAL !== 1'b0 || vid.oLVAL !== 1'b0 || vid.oDATA !== 12'h000) begin
        errors++;
        $display("FAIL idle_outputs n=%0d got fval=%b lval=%b data=%h want 0/0/000", n, vid.oFVAL, vid.oLVAL, vid.oDATA);
      end
      checks++;
      if (oFrame_Cont !== 32'd4) begin errors++; $display("FAIL idle_cnt n=%0d got %0d want 4", n, oFrame_Cont); end
      @(negedge clk);
    end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL idle_state got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    found    = 1'b0;
    iPATTERN = 2'd0;
    iSTART   = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (vid.oFVAL === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_wait_fval got 0 want 1 within 100 cycles"); end
    repeat (5) @(negedge clk);
    checks++;
    if (vid.oLVAL !== 1'b1 || vid.oDATA !== 12'h003) begin
      errors++; $display("FAIL rst_pre_active got lval=%b data=%h want 1/003", vid.oLVAL, vid.oDATA);
    end
    iRST = 1'b1;
    @(negedge clk);
    checks++; if (vid.oFVAL !== 1'b0) begin errors++; $display("FAIL rst_mid_fval got %b want 0", vid.oFVAL); end
    checks++; if (vid.oLVAL !== 1'b0) begin errors++; $display("FAIL rst_mid_lval got %b want 0", vid.oLVAL); end
    checks++; if (vid.oDATA !== 12'h000) begin errors++; $display("FAIL rst_mid_data got %h want 000", vid.oDATA); end
    checks++; if (oFrame_Cont !== 32'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", oFrame_Cont); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_start_timing();
    check_frame(0, 1, 1, 1'b0);  // ramp; pattern switched to 1 mid-frame
    check_frame(1, 2, 3, 1'b0);  // vertical ramp, back to back
    check_frame(3, 3, 2, 1'b0);  // Bayer fill
    check_frame(2, 4, 2, 1'b1);  // checker, iEND mid line 2
    test_idle_after_end();
    test_reset_mid_frame();
    test_start_timing();
    check_frame(0, 1, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
